// File: rtl/cory_unpack.sv
// cory_unpack: splits one Z-bit packed word into R N-bit lane streams with per-lane valid/ready.
// Latency: 1 cycle from word accept to o_ax_v; 1 word/cycle when every lane is ready.
// Backpressure: o_z_r low until all pending lanes fire; CORY_UNPACK_STALL_CNT_EN adds o_stall_cnt.
module cory_unpack #(
  parameter int N = 8,
  parameter int R = 2,
  parameter int Z = N * R
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_z_v,
  input  logic [Z-1:0] i_z_d,
  output logic         o_z_r,
  output logic [R-1:0] o_ax_v,
  output logic [Z-1:0] o_ax_d,
  input  logic [R-1:0] i_ax_r
`ifdef CORY_UNPACK_STALL_CNT_EN
  ,
  output logic [15:0]  o_stall_cnt
`endif
);

  logic [Z-1:0] hold_d;
  logic [R-1:0] pend;
  logic [R-1:0] fire;
  logic         acc;

`ifdef SIM
  initial begin
    if (R < 2 || R > 16 || Z != N * R) begin
      $display("ERROR: cory_unpack bad parameters N=%0d R=%0d Z=%0d", N, R, Z);
      $finish;
    end
  end
`endif

  // Ready looks through this cycle's lane fires so a word can load with no bubble.
  assign fire   = pend & i_ax_r;
  assign o_z_r  = ((pend & ~fire) == '0);
  assign acc    = i_z_v & o_z_r;
  assign o_ax_v = pend;
  assign o_ax_d = hold_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend   <= '0;
      hold_d <= '0;
    end else if (acc) begin
      pend   <= '1;
      hold_d <= i_z_d;
    end else begin
      pend   <= pend & ~fire;
    end
  end

`ifdef CORY_UNPACK_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (i_z_v && !o_z_r && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_cory_unpack.sv
// Directed vector bench for cory_unpack with R=4, N=8; counter checks when CORY_UNPACK_STALL_CNT_EN is set.
module tb_cory_unpack;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_z_v;
  logic [31:0] i_z_d;
  logic        o_z_r;
  logic [3:0]  o_ax_v;
  logic [31:0] o_ax_d;
  logic [3:0]  i_ax_r;
`ifdef CORY_UNPACK_STALL_CNT_EN
  logic [15:0] o_stall_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cory_unpack #(.N(8), .R(4), .Z(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_z_v   (i_z_v),
    .i_z_d   (i_z_d),
    .o_z_r   (o_z_r),
    .o_ax_v  (o_ax_v),
    .o_ax_d  (o_ax_d),
    .i_ax_r  (i_ax_r)
`ifdef CORY_UNPACK_STALL_CNT_EN
    ,
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic        zv;
    logic [31:0] zd;
    logic [3:0]  axr;
    logic        zr;
    logic [3:0]  axv;
    logic [31:0] axd;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst_n, input logic zv, input logic [31:0] zd, input logic [3:0] axr,
                     input logic zr, input logic [3:0] axv, input logic [31:0] axd, input logic [15:0] cnt);
    vec_t v;
    v.rst_n = rst_n; v.zv = zv; v.zd = zd; v.axr = axr;
    v.zr = zr; v.axv = axv; v.axd = axd; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic zv, input logic [31:0] zd, input logic [3:0] axr);
    reset_n = rst_n; i_z_v = zv; i_z_d = zd; i_ax_r = axr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rem;
    int         order[4];
    int         waited;

    // Each record: inputs for this cycle, then outputs expected at mid-cycle before the edge.
    add(1, 0, 32'h0,        4'h0, 1, 4'h0, 32'h0,        16'd0);
    add(1, 1, 32'h44332211, 4'h0, 1, 4'h0, 32'h0,        16'd0);
    add(1, 0, 32'h0,        4'h0, 0, 4'hF, 32'h44332211, 16'd0);
    for (int i = 0; i < 8; i++)
      add(1, 1, {4{8'(i)}}, 4'hF, 1, 4'hF, (i == 0) ? 32'h44332211 : {4{8'(i - 1)}}, 16'd0);
    add(1, 0, 32'h0,        4'hF, 1, 4'hF, 32'h07070707, 16'd0);
    add(1, 0, 32'h0,        4'h0, 1, 4'h0, 32'h07070707, 16'd0);
    add(1, 1, 32'hDDCCBBAA, 4'h0, 1, 4'h0, 32'h07070707, 16'd0);
    add(1, 1, 32'h88776655, 4'h5, 0, 4'hF, 32'hDDCCBBAA, 16'd0);
    add(1, 1, 32'h88776655, 4'h5, 0, 4'hA, 32'hDDCCBBAA, 16'd1);
    add(1, 1, 32'h88776655, 4'h5, 0, 4'hA, 32'hDDCCBBAA, 16'd2);
    add(1, 1, 32'h88776655, 4'hA, 1, 4'hA, 32'hDDCCBBAA, 16'd3);
    add(1, 0, 32'h0,        4'h0, 0, 4'hF, 32'h88776655, 16'd3);
    add(1, 0, 32'h0,        4'h3, 0, 4'hF, 32'h88776655, 16'd3);
    add(0, 0, 32'h0,        4'h0, 0, 4'hC, 32'h88776655, 16'd3);
    add(1, 0, 32'h0,        4'hF, 1, 4'h0, 32'h0,        16'd0);
    add(1, 0, 32'h0,        4'hF, 1, 4'h0, 32'h0,        16'd0);
    add(1, 1, 32'h12345678, 4'h0, 1, 4'h0, 32'h0,        16'd0);
    for (int i = 0; i < 10; i++)
      add(1, 1, 32'hCAFEF00D, 4'h0, 0, 4'hF, 32'h12345678, 16'(i));
    add(1, 1, 32'hCAFEF00D, 4'hF, 1, 4'hF, 32'h12345678, 16'd10);
    add(1, 0, 32'h0,        4'hF, 1, 4'hF, 32'hCAFEF00D, 16'd10);
    add(1, 0, 32'h0,        4'h0, 1, 4'h0, 32'hCAFEF00D, 16'd10);

    drive(0, 0, 32'h0, 4'h0);
    tick();
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].zv, tbl[i].zd, tbl[i].axr);
      @(negedge clk);
      chk("o_z_r", i, {31'd0, o_z_r}, {31'd0, tbl[i].zr});
      chk("o_ax_v", i, {28'd0, o_ax_v}, {28'd0, tbl[i].axv});
      chk("o_ax_d", i, o_ax_d, tbl[i].axd);
`ifdef CORY_UNPACK_STALL_CNT_EN
      chk("o_stall_cnt", i, {16'd0, o_stall_cnt}, {16'd0, tbl[i].cnt});
`endif
      tick();
    end

    // Lanes drained one at a time in an arbitrary order; a fired lane stays low.
    drive(1, 1, 32'hA1B2C3D4, 4'h0);
    tick();
    order[0] = 2; order[1] = 0; order[2] = 3; order[3] = 1;
    rem = 4'hF;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h0, 4'(1 << order[i]));
      @(negedge clk);
      chk("order_v", i, {28'd0, o_ax_v}, {28'd0, rem});
      chk("order_d", i, o_ax_d, 32'hA1B2C3D4);
      chk("order_zr", i, {31'd0, o_z_r}, {31'd0, (i == 3)});
      rem[order[i]] = 1'b0;
      tick();
    end
    drive(1, 0, 32'h0, 4'hF);
    @(negedge clk);
    chk("idle_v", 0, {28'd0, o_ax_v}, 32'd0);
    tick();

    // Bounded wait for a stalled word to drain once lanes reopen.
    drive(1, 1, 32'h0BADF00D, 4'h0);
    tick();
    drive(1, 1, 32'h600DCAFE, 4'h0);
    tick();
    tick();
    i_ax_r = 4'hF;
    waited = 0;
    @(negedge clk);
    while (!o_z_r && waited < 8) begin
      tick();
      waited++;
      @(negedge clk);
    end
    chk("drain_zr", waited, {31'd0, o_z_r}, 32'd1);
    tick();
    drive(1, 0, 32'h0, 4'h0);
    @(negedge clk);
    chk("drain_d", 0, o_ax_d, 32'h600DCAFE);
    chk("drain_v", 0, {28'd0, o_ax_v}, 32'hF);
    tick();

`ifdef CORY_UNPACK_STALL_CNT_EN
    drive(0, 0, 32'h0, 4'h0);
    tick();
    drive(1, 1, 32'h11111111, 4'h0);
    tick();
    drive(1, 1, 32'h22222222, 4'h0);
    for (int i = 0; i < 65540; i++) tick();
    @(negedge clk);
    chk("sat", 0, {16'd0, o_stall_cnt}, 32'h0000FFFF);
    tick();
    tick();
    @(negedge clk);
    chk("sat_hold", 1, {16'd0, o_stall_cnt}, 32'h0000FFFF);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
